icache_ctrl: RTL and testbench

Sequencing controller for the two-way instruction cache datapath. Accepts fetch requests, drives the cache's index, tag and control-code inputs, and detects misses. On a miss it runs an 8-beat memory refill into a 256-bit line buffer, writes the LRU victim way, and replays the lookup. It also executes cache-maintenance (cacop) operations and sits between the fetch stage, the cache datapath and the memory bus interface.

---
 rtl/icache_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_icache_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_ctrl.sv
// Sequencing controller for the two-way instruction cache: lookup, miss refill,
// LRU victim write-back into the data arrays and cache-maintenance (cacop) operations.
module icache_ctrl #(
   parameter int INDEX_W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req_valid,
   input  logic [31:0]  req_va,
   input  logic [31:0]  req_pa,
   output logic         req_ready,
   input  logic         cancel,
   output logic         rsp_valid,
   output logic [31:0]  rsp_ins,
   input  logic         cacop_valid,
   input  logic [1:0]   cacop_op,
   input  logic [31:0]  cacop_va,
   input  logic [31:0]  cacop_pa,
   output logic         cacop_done,
   output logic [31:0]  ad,
   output logic [31:0]  pa,
   output logic [2:0]   control_en,
   output logic         select_way,
   output logic         wlru_en,
   input  logic         rlru,
   input  logic         hit,
   input  logic [31:0]  ins,
   output logic [255:0] r_data,
   output logic         rd_req,
   output logic [31:0]  rd_addr,
   input  logic         rd_rdy,
   input  logic         ret_valid,
   input  logic         ret_last,
   input  logic [31:0]  ret_data
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_LOOKUP,
      S_MISS,
      S_REFILL,
      S_WRITE,
      S_REREAD,
      S_CACOP_TAG,
      S_CACOP_IDX,
      S_CACOP_LK,
      S_CACOP_INV0,
      S_CACOP_INV1,
      S_DONE
   } state_t;

   state_t         r_state;
   logic [31:0]    r_va;
   logic [31:0]    r_pa;
   logic [31:0]    r_cva;
   logic [31:0]    r_cpa;
   logic           r_victim;
   logic [2:0]     r_cnt;
   logic [255:0]   r_line;
   logic           r_cancelled;
   logic           r_replay;
   logic           r_cmp;
   logic           w_lookupHit;
   logic [31:0]    w_invAd;

   assign w_lookupHit = hit && !cancel;

   // Invalidate address keeps only tag and index; bit 0 is overwritten with the way
   assign w_invAd = {r_cva[31:INDEX_W+5], r_cva[INDEX_W+4:5], 5'b0};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_va        <= '0;
         r_pa        <= '0;
         r_cva       <= '0;
         r_cpa       <= '0;
         r_victim    <= 1'b0;
         r_cnt       <= '0;
         r_line      <= '0;
         r_cancelled <= 1'b0;
         r_replay    <= 1'b0;
         r_cmp       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_replay <= 1'b0;
               if (cacop_valid) begin
                  r_cva <= cacop_va;
                  r_cpa <= cacop_pa;
                  r_cmp <= 1'b0;
                  case (cacop_op)
                     2'd0:    r_state <= S_CACOP_TAG;
                     2'd1:    r_state <= S_CACOP_IDX;
                     2'd2:    r_state <= S_CACOP_LK;
                     default: r_state <= S_DONE;
                  endcase
               end else if (req_valid) begin
                  r_va    <= req_va;
                  r_state <= S_LOOKUP;
               end
            end
            // A replayed lookup keeps the physical address captured on the original miss
            S_LOOKUP: begin
               if (!r_replay) r_pa <= req_pa;
               r_replay <= 1'b0;
               if (cancel) begin
                  r_state <= S_IDLE;
               end else if (hit) begin
                  if (req_valid) begin
                     r_va    <= req_va;
                     r_state <= S_LOOKUP;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_victim    <= ~rlru;
                  r_cancelled <= 1'b0;
                  r_state     <= S_MISS;
               end
            end
            S_MISS: begin
               if (cancel) r_cancelled <= 1'b1;
               if (rd_rdy) begin
                  r_cnt   <= '0;
                  r_state <= S_REFILL;
               end
            end
            S_REFILL: begin
               if (cancel) r_cancelled <= 1'b1;
               if (ret_valid) begin
                  r_line[{r_cnt, 5'b0} +: 32] <= ret_data;
                  r_cnt <= r_cnt + 3'd1;
                  if (ret_last) r_state <= S_WRITE;
               end
            end
            S_WRITE: begin
               if (r_cancelled || cancel) begin
                  r_cancelled <= 1'b0;
                  r_state     <= S_IDLE;
               end else begin
                  r_state <= S_REREAD;
               end
            end
            S_REREAD: begin
               if (cancel) begin
                  r_state <= S_IDLE;
               end else begin
                  r_replay <= 1'b1;
                  r_state  <= S_LOOKUP;
               end
            end
            S_CACOP_TAG:  r_state <= S_DONE;
            S_CACOP_IDX:  r_state <= S_DONE;
            // First cycle reads the set, second cycle compares against cacop_pa
            S_CACOP_LK: begin
               if (!r_cmp) begin
                  r_cmp <= 1'b1;
               end else begin
                  r_cmp   <= 1'b0;
                  r_state <= hit ? S_CACOP_INV0 : S_DONE;
               end
            end
            S_CACOP_INV0: r_state <= S_CACOP_INV1;
            S_CACOP_INV1: r_state <= S_DONE;
            S_DONE:       r_state <= S_IDLE;
            default:      r_state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      req_ready  = 1'b0;
      rsp_valid  = 1'b0;
      rsp_ins    = '0;
      cacop_done = 1'b0;
      ad         = r_va;
      pa         = r_pa;
      control_en = 3'd0;
      select_way = 1'b0;
      wlru_en    = 1'b0;
      rd_req     = 1'b0;
      rd_addr    = {r_pa[31:5], 5'b0};
      r_data     = r_line;
      case (r_state)
         S_IDLE: begin
            req_ready = !cacop_valid && !rst;
            ad        = req_va;
         end
         S_LOOKUP: begin
            pa = r_replay ? r_pa : req_pa;
            if (w_lookupHit) begin
               rsp_valid = 1'b1;
               rsp_ins   = ins;
               wlru_en   = 1'b1;
               req_ready = !rst;
               if (req_valid) ad = req_va;
            end
         end
         S_MISS:   rd_req = 1'b1;
         S_WRITE: begin
            control_en = 3'd4;
            select_way = r_victim;
         end
         S_CACOP_TAG: begin
            control_en = 3'd1;
            ad         = r_cva;
         end
         S_CACOP_IDX: begin
            control_en = 3'd2;
            ad         = r_cva;
         end
         S_CACOP_LK: begin
            ad = r_cva;
            if (r_cmp) pa = r_cpa;
         end
         S_CACOP_INV0: begin
            control_en = 3'd3;
            ad         = {w_invAd[31:1], 1'b0};
         end
         S_CACOP_INV1: begin
            control_en = 3'd3;
            ad         = {w_invAd[31:1], 1'b1};
         end
         S_DONE:   cacop_done = 1'b1;
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed self-checking bench for icache_ctrl with a small two-way cache array model
// standing in for the datapath (synchronous read of ad, tag compare against pa).
module tb_icache_ctrl;

   logic         clk;
   logic         rst;
   logic         req_valid;
   logic [31:0]  req_va;
   logic [31:0]  req_pa;
   logic         req_ready;
   logic         cancel;
   logic         rsp_valid;
   logic [31:0]  rsp_ins;
   logic         cacop_valid;
   logic [1:0]   cacop_op;
   logic [31:0]  cacop_va;
   logic [31:0]  cacop_pa;
   logic         cacop_done;
   logic [31:0]  ad;
   logic [31:0]  pa;
   logic [2:0]   control_en;
   logic         select_way;
   logic         wlru_en;
   logic         rlru;
   logic         hit;
   logic [31:0]  ins;
   logic [255:0] r_data;
   logic         rd_req;
   logic [31:0]  rd_addr;
   logic         rd_rdy;
   logic         ret_valid;
   logic         ret_last;
   logic [31:0]  ret_data;

   int testCount = 0;
   int failCount = 0;

   icache_ctrl #(.INDEX_W(8)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_va(req_va), .req_pa(req_pa), .req_ready(req_ready),
      .cancel(cancel), .rsp_valid(rsp_valid), .rsp_ins(rsp_ins),
      .cacop_valid(cacop_valid), .cacop_op(cacop_op), .cacop_va(cacop_va),
      .cacop_pa(cacop_pa), .cacop_done(cacop_done),
      .ad(ad), .pa(pa), .control_en(control_en), .select_way(select_way),
      .wlru_en(wlru_en), .rlru(rlru), .hit(hit), .ins(ins), .r_data(r_data),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
      .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cache array model: two ways, 256 sets, 8 words per line, tag = pa[31:13]
   logic [31:0] mData [2][256][8];
   logic [18:0] mTag  [2][256];
   logic        mValid[2][256];
   logic [31:0] rdAd;
   logic        mInit;
   logic [7:0]  mIdx;
   logic [2:0]  mWord;
   logic        mHit0;
   logic        mHit1;

   always @(posedge clk) begin
      rdAd <= ad;
      if (mInit) begin
         for (int w = 0; w < 2; w++)
            for (int i = 0; i < 256; i++) mValid[w][i] = 1'b0;
         for (int k = 0; k < 8; k++) begin
            mData[0][8'h80][k] = k;
            mData[1][8'h80][k] = 32'h300 + k;
         end
         mTag[0][8'h80]   = 19'd0;
         mTag[1][8'h80]   = 19'd1;
         mValid[0][8'h80] = 1'b1;
         mValid[1][8'h80] = 1'b1;
      end else if (control_en == 3'd4) begin
         for (int k = 0; k < 8; k++) mData[select_way][ad[12:5]][k] = r_data[32*k +: 32];
         mTag[select_way][ad[12:5]]   = pa[31:13];
         mValid[select_way][ad[12:5]] = 1'b1;
      end else if (control_en == 3'd1 || control_en == 3'd2 || control_en == 3'd3) begin
         mValid[ad[0]][ad[12:5]] = 1'b0;
      end
   end

   always_comb begin
      mIdx  = rdAd[12:5];
      mWord = rdAd[4:2];
      mHit0 = mValid[0][mIdx] && (mTag[0][mIdx] == pa[31:13]);
      mHit1 = mValid[1][mIdx] && (mTag[1][mIdx] == pa[31:13]);
      hit   = mHit0 || mHit1;
      ins   = mHit0 ? mData[0][mIdx][mWord] : (mHit1 ? mData[1][mIdx][mWord] : 32'h0);
   end

   task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      testCount++;
      if (obs !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic nextCycle;
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus;
      logic [255:0] expLine;

      // Reset state
      rst = 1'b1; mInit = 1'b1;
      req_valid = 0; req_va = 0; req_pa = 0; cancel = 0;
      cacop_valid = 0; cacop_op = 0; cacop_va = 0; cacop_pa = 0;
      rlru = 0; rd_rdy = 0; ret_valid = 0; ret_last = 0; ret_data = 0;
      nextCycle;
      mInit = 1'b0;
      #1;
      checkOutput("rst_rsp_valid", rsp_valid, 0);
      checkOutput("rst_cacop_done", cacop_done, 0);
      checkOutput("rst_rd_req", rd_req, 0);
      checkOutput("rst_wlru_en", wlru_en, 0);
      checkOutput("rst_select_way", select_way, 0);
      checkOutput("rst_control_en", control_en, 0);
      checkOutput("rst_req_ready", req_ready, 0);
      nextCycle;
      rst = 1'b0;

      // Back-to-back hits on the resident line at 0x1000
      req_valid = 1; req_va = 32'h1000; #1;
      checkOutput("idle_ready", req_ready, 1);
      checkOutput("idle_ad", ad, 32'h1000);
      nextCycle;
      req_va = 32'h1004; req_pa = 32'h1000; #1;
      checkOutput("b2b0_valid", rsp_valid, 1);
      checkOutput("b2b0_ins", rsp_ins, 0);
      checkOutput("b2b0_wlru", wlru_en, 1);
      checkOutput("b2b0_ready", req_ready, 1);
      checkOutput("b2b0_ad", ad, 32'h1004);
      nextCycle;
      req_va = 32'h1008; req_pa = 32'h1004; #1;
      checkOutput("b2b1_valid", rsp_valid, 1);
      checkOutput("b2b1_ins", rsp_ins, 1);
      checkOutput("b2b1_wlru", wlru_en, 1);
      nextCycle;
      req_valid = 0; req_pa = 32'h1008; #1;
      checkOutput("b2b2_valid", rsp_valid, 1);
      checkOutput("b2b2_ins", rsp_ins, 2);
      checkOutput("b2b2_wlru", wlru_en, 1);
      nextCycle; #1;
      checkOutput("b2b_end_valid", rsp_valid, 0);

      // Cold miss at 0x2010, victim way 0, with a junk beat before refill and a bubble
      req_valid = 1; req_va = 32'h2010; rlru = 1;
      nextCycle;
      req_valid = 0; req_pa = 32'h2010; ret_valid = 1; ret_data = 32'hDEAD; #1;
      checkOutput("miss_no_rsp", rsp_valid, 0);
      nextCycle; #1;
      checkOutput("miss_rd_req", rd_req, 1);
      checkOutput("miss_rd_addr", rd_addr, 32'h2000);
      nextCycle;
      ret_valid = 0; rd_rdy = 1; #1;
      checkOutput("miss_hold_req", rd_req, 1);
      checkOutput("miss_hold_addr", rd_addr, 32'h2000);
      nextCycle;
      rd_rdy = 0;
      for (int k = 0; k < 8; k++) begin
         if (k == 3) begin
            ret_valid = 0; ret_last = 0;
            nextCycle;
         end
         ret_valid = 1; ret_data = 32'hA0 + k; ret_last = (k == 7);
         expLine[32*k +: 32] = 32'hA0 + k;
         nextCycle;
      end
      ret_valid = 0; ret_last = 0; #1;
      checkOutput("fill_write_en", control_en, 4);
      checkOutput("fill_write_way", select_way, 0);
      checkOutput("fill_write_ad", ad, 32'h2010);
      checkOutput("fill_write_line", r_data, expLine);
      nextCycle; #1;
      checkOutput("reread_en", control_en, 0);
      checkOutput("reread_ad", ad, 32'h2010);
      checkOutput("reread_no_rsp", rsp_valid, 0);
      nextCycle; #1;
      checkOutput("replay_valid", rsp_valid, 1);
      checkOutput("replay_ins", rsp_ins, 32'hA4);
      checkOutput("replay_wlru", wlru_en, 1);
      nextCycle; #1;
      checkOutput("replay_end", rsp_valid, 0);

      // Miss with rlru = 0 selects way 1; single-beat refill
      req_valid = 1; req_va = 32'h4020; rlru = 0;
      nextCycle;
      req_valid = 0; req_pa = 32'h4020;
      nextCycle;
      rd_rdy = 1; #1;
      checkOutput("miss2_rd_addr", rd_addr, 32'h4020);
      nextCycle;
      rd_rdy = 0; ret_valid = 1; ret_data = 32'hB0; ret_last = 1;
      nextCycle;
      ret_valid = 0; ret_last = 0; #1;
      checkOutput("miss2_write_en", control_en, 4);
      checkOutput("miss2_write_way", select_way, 1);
      nextCycle;
      nextCycle; #1;
      checkOutput("miss2_ins", rsp_ins, 32'hB0);
      checkOutput("miss2_valid", rsp_valid, 1);
      nextCycle;

      // cacop index-invalidate way 1, arriving together with a fetch request
      cacop_valid = 1; cacop_op = 1; cacop_va = 32'h1001; cacop_pa = 0;
      req_valid = 1; req_va = 32'h1000; #1;
      checkOutput("cop1_req_ready", req_ready, 0);
      nextCycle;
      cacop_valid = 0; #1;
      checkOutput("cop1_en", control_en, 2);
      checkOutput("cop1_ad", ad, 32'h1001);
      checkOutput("cop1_not_done", cacop_done, 0);
      checkOutput("cop1_busy", req_ready, 0);
      nextCycle; #1;
      checkOutput("cop1_done_en", control_en, 0);
      checkOutput("cop1_done", cacop_done, 1);
      nextCycle; #1;
      checkOutput("cop1_after_ready", req_ready, 1);
      checkOutput("cop1_after_done", cacop_done, 0);
      nextCycle;
      req_valid = 0; req_pa = 32'h1000; #1;
      checkOutput("cop1_fetch_valid", rsp_valid, 1);
      checkOutput("cop1_fetch_ins", rsp_ins, 0);
      nextCycle;

      // Hit-invalidate on 0x1000: hit path, then miss path
      cacop_valid = 1; cacop_op = 2; cacop_va = 32'h1000; cacop_pa = 32'h1000;
      nextCycle;
      cacop_valid = 0; #1;
      checkOutput("hinv_lk_ad", ad, 32'h1000);
      checkOutput("hinv_lk_en", control_en, 0);
      nextCycle; #1;
      checkOutput("hinv_cmp_pa", pa, 32'h1000);
      checkOutput("hinv_cmp_done", cacop_done, 0);
      nextCycle; #1;
      checkOutput("hinv_inv0_en", control_en, 3);
      checkOutput("hinv_inv0_ad", ad, 32'h1000);
      nextCycle; #1;
      checkOutput("hinv_inv1_en", control_en, 3);
      checkOutput("hinv_inv1_ad", ad, 32'h1001);
      nextCycle; #1;
      checkOutput("hinv_hit_done", cacop_done, 1);
      nextCycle;
      cacop_valid = 1;
      nextCycle;
      cacop_valid = 0;
      nextCycle;
      nextCycle; #1;
      checkOutput("hinv_miss_done", cacop_done, 1);
      checkOutput("hinv_miss_en", control_en, 0);
      nextCycle;

      // cancel during refill beat 3: line still written, no response
      req_valid = 1; req_va = 32'h5000; rlru = 0;
      nextCycle;
      req_valid = 0; req_pa = 32'h5000;
      nextCycle;
      rd_rdy = 1;
      nextCycle;
      rd_rdy = 0;
      for (int k = 0; k < 8; k++) begin
         ret_valid = 1; ret_data = 32'hC0 + k; ret_last = (k == 7); cancel = (k == 3); #1;
         checkOutput("cancel_fill_rsp", rsp_valid, 0);
         nextCycle;
      end
      cancel = 0; ret_valid = 0; ret_last = 0; #1;
      checkOutput("cancel_write_en", control_en, 4);
      checkOutput("cancel_write_rsp", rsp_valid, 0);
      nextCycle; #1;
      checkOutput("cancel_idle_en", control_en, 0);
      checkOutput("cancel_idle_rsp", rsp_valid, 0);
      checkOutput("cancel_idle_ready", req_ready, 1);
      nextCycle; #1;
      checkOutput("cancel_late_rsp", rsp_valid, 0);

      // Reset in the middle of a refill
      req_valid = 1; req_va = 32'h6040;
      nextCycle;
      req_valid = 0; req_pa = 32'h6040;
      nextCycle;
      rd_rdy = 1;
      nextCycle;
      rd_rdy = 0; ret_valid = 1; ret_data = 32'h70;
      nextCycle;
      ret_data = 32'h71;
      nextCycle;
      ret_data = 32'h72; rst = 1;
      nextCycle;
      ret_data = 32'h73; #1;
      checkOutput("mrst_rsp_valid", rsp_valid, 0);
      checkOutput("mrst_cacop_done", cacop_done, 0);
      checkOutput("mrst_rd_req", rd_req, 0);
      checkOutput("mrst_wlru_en", wlru_en, 0);
      checkOutput("mrst_select_way", select_way, 0);
      checkOutput("mrst_control_en", control_en, 0);
      checkOutput("mrst_req_ready", req_ready, 0);
      checkOutput("mrst_line", r_data, 0);
      nextCycle;
      rst = 0; ret_data = 32'h74; #1;
      checkOutput("mrst_idle_rd_req", rd_req, 0);
      checkOutput("mrst_idle_en", control_en, 0);
      nextCycle;
      ret_data = 32'h75; ret_last = 1; #1;
      checkOutput("mrst_last_en", control_en, 0);
      nextCycle;
      ret_valid = 0; ret_last = 0; req_valid = 1; req_va = 32'h6040; #1;
      checkOutput("mrst_new_ready", req_ready, 1);
      nextCycle;
      req_valid = 0; req_pa = 32'h6040; #1;
      checkOutput("mrst_new_no_rsp", rsp_valid, 0);
      nextCycle; #1;
      checkOutput("mrst_new_rd_req", rd_req, 1);
      checkOutput("mrst_new_rd_addr", rd_addr, 32'h6040);
      checkOutput("mrst_new_line", r_data, 0);
   endtask

   initial begin
      applyStimulus();
      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
